// File: rtl/multi_lane_port_lookup.sv
// Output-port stage: buffers NUM_LANES data lanes with a shared ctrl bus,
// pairs each packet with its upstream port decision, stamps that decision
// into the IOQ module header on every lane, and forwards or drops the packet.
module multi_lane_port_lookup #(
  parameter int DATA_WIDTH        = 64,
  parameter int CTRL_WIDTH        = DATA_WIDTH / 8,
  parameter int NUM_LANES         = 2,
  parameter int NUM_OUTPUT_QUEUES = 8,
  parameter int PKT_FIFO_BITS     = 4,
  parameter int DEC_FIFO_BITS     = 2,
  parameter logic [CTRL_WIDTH-1:0] IOQ_CTRL = {CTRL_WIDTH{1'b1}},
  parameter int DST_PORT_POS      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]   in_data,
  input  logic [CTRL_WIDTH-1:0]             in_ctrl,
  input  logic                              in_wr,
  output logic                              in_rdy,
  input  logic [NUM_OUTPUT_QUEUES-1:0]      dec_ports,
  input  logic                              dec_wr,
  output logic [NUM_LANES*DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]             out_ctrl,
  output logic                              out_wr,
  input  logic                              out_rdy,
  output logic [31:0]                       fwd_count,
  output logic [31:0]                       drop_count
);

  localparam int BUS_W      = NUM_LANES * DATA_WIDTH;
  localparam int WORD_W     = BUS_W + CTRL_WIDTH;
  localparam int WORD_DEPTH = 1 << PKT_FIFO_BITS;
  localparam int DEC_DEPTH  = 1 << DEC_FIFO_BITS;
  // Two slots of margin on the word FIFO, one on the decision FIFO, so a
  // word or decision already in flight when in_rdy falls still fits.
  localparam logic [PKT_FIFO_BITS:0] WORD_NEARLY_FULL = (PKT_FIFO_BITS+1)'(WORD_DEPTH - 2);
  localparam logic [DEC_FIFO_BITS:0] DEC_NEARLY_FULL  = (DEC_FIFO_BITS+1)'(DEC_DEPTH - 1);

  typedef enum logic [4:0] {
    IDLE      = 5'b00001,
    WRITE_HDR = 5'b00010,
    SKIP_HDRS = 5'b00100,
    WAIT_EOP  = 5'b01000,
    DROP      = 5'b10000
  } state_t;

  state_t state, state_next;

  logic [WORD_W-1:0]            word_mem [WORD_DEPTH];
  logic [PKT_FIFO_BITS-1:0]     word_wr_ptr, word_rd_ptr;
  logic [PKT_FIFO_BITS:0]       word_count;
  logic [NUM_OUTPUT_QUEUES-1:0] dec_mem [DEC_DEPTH];
  logic [DEC_FIFO_BITS-1:0]     dec_wr_ptr, dec_rd_ptr;
  logic [DEC_FIFO_BITS:0]       dec_count;

  logic [WORD_W-1:0]            head_word;
  logic [CTRL_WIDTH-1:0]        head_ctrl;
  logic [BUS_W-1:0]             head_data;
  logic [NUM_OUTPUT_QUEUES-1:0] dec_head;
  logic [NUM_OUTPUT_QUEUES-1:0] held_dec;
  logic                         word_avail, dec_avail;
  logic                         word_pop, dec_pop;
  logic                         hdr_rewrite, fwd_inc, drop_inc, drop_mark_data;
  logic                         drop_in_data;

  assign word_avail = (word_count != '0);
  assign dec_avail  = (dec_count != '0);
  assign head_word  = word_mem[word_rd_ptr];
  assign head_ctrl  = head_word[WORD_W-1 -: CTRL_WIDTH];
  assign head_data  = head_word[BUS_W-1:0];
  assign dec_head   = dec_mem[dec_rd_ptr];
  assign out_ctrl   = head_ctrl;
  assign in_rdy     = (word_count < WORD_NEARLY_FULL) && (dec_count < DEC_NEARLY_FULL);

  // Word FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (in_wr) word_mem[word_wr_ptr] <= {in_ctrl, in_data};
  end

  // Word FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      word_wr_ptr <= '0;
      word_rd_ptr <= '0;
      word_count  <= '0;
    end else begin
      if (in_wr)    word_wr_ptr <= word_wr_ptr + 1'b1;
      if (word_pop) word_rd_ptr <= word_rd_ptr + 1'b1;
      case ({in_wr, word_pop})
        2'b10:   word_count <= word_count + 1'b1;
        2'b01:   word_count <= word_count - 1'b1;
        default: word_count <= word_count;
      endcase
    end
  end

  // Decision FIFO storage.
  always_ff @(posedge clk) begin
    if (dec_wr) dec_mem[dec_wr_ptr] <= dec_ports;
  end

  // Decision FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dec_wr_ptr <= '0;
      dec_rd_ptr <= '0;
      dec_count  <= '0;
    end else begin
      if (dec_wr)  dec_wr_ptr <= dec_wr_ptr + 1'b1;
      if (dec_pop) dec_rd_ptr <= dec_rd_ptr + 1'b1;
      case ({dec_wr, dec_pop})
        2'b10:   dec_count <= dec_count + 1'b1;
        2'b01:   dec_count <= dec_count - 1'b1;
        default: dec_count <= dec_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state: walk header words, then data words, until EOP.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (dec_avail && word_avail) state_next = (dec_head == '0) ? DROP : WRITE_HDR;
      WRITE_HDR: if (word_avail && out_rdy) state_next = SKIP_HDRS;
      SKIP_HDRS: if (word_avail && out_rdy && head_ctrl == '0) state_next = WAIT_EOP;
      WAIT_EOP:  if (word_avail && out_rdy && head_ctrl != '0) state_next = IDLE;
      DROP:      if (word_avail && drop_in_data && head_ctrl != '0) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM outputs: pops, output valid, header rewrite and counter strobes.
  always_comb begin
    word_pop       = 1'b0;
    dec_pop        = 1'b0;
    out_wr         = 1'b0;
    hdr_rewrite    = 1'b0;
    fwd_inc        = 1'b0;
    drop_inc       = 1'b0;
    drop_mark_data = 1'b0;
    case (state)
      IDLE: dec_pop = dec_avail && word_avail;
      WRITE_HDR: begin
        out_wr      = word_avail && out_rdy;
        word_pop    = out_wr;
        hdr_rewrite = (head_ctrl == IOQ_CTRL);
      end
      SKIP_HDRS: begin
        out_wr   = word_avail && out_rdy;
        word_pop = out_wr;
      end
      WAIT_EOP: begin
        out_wr   = word_avail && out_rdy;
        word_pop = out_wr;
        fwd_inc  = out_wr && (head_ctrl != '0);
      end
      DROP: begin
        word_pop       = word_avail;
        drop_mark_data = word_avail && (head_ctrl == '0);
        drop_inc       = word_avail && drop_in_data && (head_ctrl != '0);
      end
      default: ;
    endcase
  end

  // Stamp the held decision into the dst-port field of every lane on the IOQ header.
  always_comb begin
    out_data = head_data;
    if (hdr_rewrite) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        out_data[i*DATA_WIDTH + DST_PORT_POS +: NUM_OUTPUT_QUEUES] = held_dec;
      end
    end
  end

  // Held decision and the header/data phase flag used while dropping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      held_dec     <= '0;
      drop_in_data <= 1'b0;
    end else begin
      if (dec_pop) held_dec <= dec_head;
      if (state == IDLE)       drop_in_data <= 1'b0;
      else if (drop_mark_data) drop_in_data <= 1'b1;
    end
  end

  // Saturating forward/drop packet counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (fwd_inc && fwd_count != 32'hFFFF_FFFF)   fwd_count  <= fwd_count + 32'd1;
      if (drop_inc && drop_count != 32'hFFFF_FFFF) drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_multi_lane_port_lookup.sv
// Directed bench for multi_lane_port_lookup with a scoreboard of expected output words.
module tb_multi_lane_port_lookup;

  localparam int DW    = 64;
  localparam int LANES = 2;
  localparam int CW    = 8;
  localparam int BUS_W = DW * LANES;
  localparam int WW    = BUS_W + CW;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [BUS_W-1:0] in_data = '0;
  logic [CW-1:0]    in_ctrl = '0;
  logic             in_wr = 1'b0;
  logic             in_rdy;
  logic [7:0]       dec_ports = '0;
  logic             dec_wr = 1'b0;
  logic [BUS_W-1:0] out_data;
  logic [CW-1:0]    out_ctrl;
  logic             out_wr;
  logic             out_rdy = 1'b1;
  logic [31:0]      fwd_count;
  logic [31:0]      drop_count;

  int check_count = 0;
  int error_count = 0;
  logic [WW-1:0] exp_q [$];
  logic [WW-1:0] pkt [$];

  multi_lane_port_lookup dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_wr(in_wr), .in_rdy(in_rdy),
    .dec_ports(dec_ports), .dec_wr(dec_wr),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr), .out_rdy(out_rdy),
    .fwd_count(fwd_count), .drop_count(drop_count)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drive one word for one cycle; called at posedge+1, returns at next posedge+1.
  task automatic applyStimulus(input logic [WW-1:0] w);
    in_ctrl = w[WW-1 -: CW];
    in_data = w[BUS_W-1:0];
    in_wr   = 1'b1;
    @(posedge clk); #1;
    in_wr   = 1'b0;
  endtask

  task automatic sendDecision(input logic [7:0] d);
    dec_ports = d;
    dec_wr    = 1'b1;
    @(posedge clk); #1;
    dec_wr    = 1'b0;
  endtask

  // Header words first (IOQ word leads), then data, last data word carries EOP ctrl.
  task automatic buildPacket(input int n_hdr, input int n_data);
    logic [WW-1:0] w;
    pkt.delete();
    for (int i = 0; i < n_hdr + n_data; i++) begin
      w[BUS_W-1:0] = {$urandom, $urandom, $urandom, $urandom};
      if (i == 0)                      w[WW-1 -: CW] = 8'hFF;
      else if (i < n_hdr)              w[WW-1 -: CW] = 8'h02;
      else if (i == n_hdr + n_data - 1) w[WW-1 -: CW] = 8'h80;
      else                              w[WW-1 -: CW] = 8'h00;
      pkt.push_back(w);
    end
  endtask

  // Reference: only the IOQ header word changes, dst-port byte on every lane.
  task automatic pushExpected(input logic [7:0] d);
    logic [WW-1:0] w;
    for (int i = 0; i < pkt.size(); i++) begin
      w = pkt[i];
      if (w[WW-1 -: CW] == 8'hFF) begin
        for (int l = 0; l < LANES; l++) w[l*DW + 16 +: 8] = d;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic sendPacket();
    for (int i = 0; i < pkt.size(); i++) applyStimulus(pkt[i]);
  endtask

  task automatic waitDrain(input string tag);
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    checkOutput(tag, exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    // Output monitor: every out_wr must match the head of the scoreboard.
    fork
      forever begin
        logic [WW-1:0] e;
        @(negedge clk);
        if (reset === 1'b1 && out_wr === 1'b1) begin
          if (exp_q.size() == 0) checkOutput("unexpected_out_wr", out_wr, 0);
          else begin
            e = exp_q.pop_front();
            checkOutput("out_word", {out_ctrl, out_data}, e);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("reset_out_wr", out_wr, 0);
    checkOutput("reset_fwd", fwd_count, 0);
    checkOutput("reset_drop", drop_count, 0);
    checkOutput("reset_in_rdy", in_rdy, 1);

    // 1: single IOQ header + 8 data words forwarded with decision 05
    buildPacket(1, 8);
    pushExpected(8'h05);
    sendDecision(8'h05);
    sendPacket();
    waitDrain("t1_drain");
    checkOutput("t1_fwd", fwd_count, 1);

    // 2: all-zero decision drops a 6-word packet even with out_rdy low
    out_rdy = 1'b0;
    buildPacket(1, 5);
    sendDecision(8'h00);
    sendPacket();
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t2_drop", drop_count, 1);
    checkOutput("t2_fwd", fwd_count, 1);
    checkOutput("t2_in_rdy", in_rdy, 1);

    // 3: out_rdy toggling across a 10-word packet
    sendDecision(8'h3C);
    buildPacket(1, 9);
    pushExpected(8'h3C);
    sendPacket();
    for (int c = 0; c < 80 && exp_q.size() != 0; c++) begin
      out_rdy = ~out_rdy;
      @(posedge clk); #1;
    end
    out_rdy = 1'b1;
    waitDrain("t3_drain");
    checkOutput("t3_fwd", fwd_count, 2);

    // 4: three back-to-back packets, middle one dropped
    sendDecision(8'h01);
    sendDecision(8'h00);
    sendDecision(8'h40);
    buildPacket(1, 2);
    pushExpected(8'h01);
    sendPacket();
    buildPacket(1, 2);
    sendPacket();
    buildPacket(1, 2);
    pushExpected(8'h40);
    sendPacket();
    waitDrain("t4_drain");
    checkOutput("t4_fwd", fwd_count, 4);
    checkOutput("t4_drop", drop_count, 2);

    // 5: words wait for a late decision; two header words exercise header skipping
    buildPacket(2, 4);
    sendPacket();
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t5_hold_out_wr", out_wr, 0);
    pushExpected(8'h81);
    sendDecision(8'h81);
    waitDrain("t5_drain");
    checkOutput("t5_fwd", fwd_count, 5);

    // 6: reset while in WAIT_EOP, then a clean packet
    out_rdy = 1'b0;
    sendDecision(8'h0F);
    buildPacket(1, 7);
    pushExpected(8'h0F);
    sendPacket();
    out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_rdy = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_q.delete();
    checkOutput("t6_out_wr", out_wr, 0);
    checkOutput("t6_fwd", fwd_count, 0);
    checkOutput("t6_drop", drop_count, 0);
    checkOutput("t6_in_rdy", in_rdy, 1);
    out_rdy = 1'b1;
    sendDecision(8'h22);
    buildPacket(1, 3);
    pushExpected(8'h22);
    sendPacket();
    waitDrain("t6_drain");
    checkOutput("t6_fwd_after", fwd_count, 1);
    checkOutput("t6_drop_after", drop_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
